// File: rtl/gate_barrier_ctrl_if.sv
// Barrier controller bus: authorisation, loop sensor and alarm-clear in; motor/status out.
// Latency: none (wiring only).
// Backpressure: none; open_cmd is a one-cycle pulse, queued inside the controller.
//
// Signals:
//   open_cmd        authorisation pulse from the occupancy controller
//   car_present     loop sensor under the barrier (synchronous, debounced)
//   alarm_clr       clears the sticky tailgate alarm
//   motor_up        drive barrier up
//   motor_down      drive barrier down
//   barrier_open    barrier fully raised
//   pend_cnt        authorisations not yet consumed
//   tailgate_alarm  sticky tailgate alarm
interface gate_barrier_ctrl_if #(
  parameter int PEND_W = 2
);
  logic              open_cmd;
  logic              car_present;
  logic              alarm_clr;
  logic              motor_up;
  logic              motor_down;
  logic              barrier_open;
  logic [PEND_W-1:0] pend_cnt;
  logic              tailgate_alarm;

  // Stimulus side (occupancy controller + sensors)
  modport master (
    output open_cmd, car_present, alarm_clr,
    input  motor_up, motor_down, barrier_open, pend_cnt, tailgate_alarm
  );

  // Barrier controller side
  modport slave (
    input  open_cmd, car_present, alarm_clr,
    output motor_up, motor_down, barrier_open, pend_cnt, tailgate_alarm
  );
endinterface

// File: rtl/gate_barrier_ctrl.sv
// Barrier motor controller for one garage door: queues authorisations, raises, holds, lowers.
// Latency: open_cmd -> pend_cnt 1 cycle, -> motor_up 2 cycles; all outputs registered.
// Backpressure: none; authorisations queue in pend_cnt, saturating at 2^PEND_W-1.
//
// Ports: clock, reset_n (async active-low), bus (gate_barrier_ctrl_if.slave, see interface).
// Optional feature: define GATE_TAILGATE_ALARM_EN to build the sticky tailgate alarm;
// otherwise tailgate_alarm is tied 0 and alarm_clr is ignored.
// The interface PEND_W must match this module's PEND_W.
module gate_barrier_ctrl #(
  parameter int MOVE_CYCLES = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMER_W     = 5,
  parameter int PEND_W      = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  gate_barrier_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] MOVE_LOAD = TIMER_W'(MOVE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX  = '1;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PEND_W-1:0]  pend_q,  pend_d;
  logic               car_prev;
  logic               motor_up_q, motor_down_q, barrier_open_q;

  logic timer_zero;
  logic pend_zero;
  logic pass_evt;
  logic consume;

  assign timer_zero = (timer_q == '0);
  assign pend_zero  = (pend_q == '0);

  // A car has finished crossing the loop while the barrier is up.
  assign pass_evt = (state_q == OPEN) && car_prev && !bus.car_present;

  // One authorisation is used up by a passage, or abandoned when the hold
  // timer runs out with nobody on the loop.
  assign consume = (state_q == OPEN) &&
                   (pass_evt || (timer_zero && !bus.car_present));

  // Pending-authorisation counter. A simultaneous grant and consume cancel
  // out, even when the counter is saturated.
  always_comb begin
    pend_d = pend_q;
    if (bus.open_cmd && consume) begin
      pend_d = pend_q;
    end else if (bus.open_cmd) begin
      if (pend_q != PEND_MAX) pend_d = pend_q + PEND_W'(1);
    end else if (consume) begin
      if (!pend_zero) pend_d = pend_q - PEND_W'(1);
    end
  end

  // Next-state and timer. Move decisions use the registered pend_cnt, so a
  // fresh open_cmd needs one cycle to land before it can start the motor.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      CLOSED: begin
        if (!pend_zero) begin
          state_d = OPENING;
          timer_d = MOVE_LOAD;
        end
      end
      OPENING: begin
        if (timer_zero) begin
          state_d = OPEN;
          timer_d = HOLD_LOAD;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      OPEN: begin
        if (pend_zero && !bus.car_present) begin
          state_d = CLOSING;
          timer_d = MOVE_LOAD;
        end else if (bus.car_present || consume) begin
          // Occupied loop holds the barrier; a consumed authorisation
          // gives the next queued car a fresh hold window.
          timer_d = HOLD_LOAD;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      CLOSING: begin
        // Safety reversal and new authorisations both restart a full rise,
        // and take precedence over reaching the bottom.
        if (bus.car_present || !pend_zero) begin
          state_d = OPENING;
          timer_d = MOVE_LOAD;
        end else if (timer_zero) begin
          state_d = CLOSED;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d = CLOSED;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= CLOSED;
      timer_q        <= '0;
      pend_q         <= '0;
      car_prev       <= 1'b0;
      motor_up_q     <= 1'b0;
      motor_down_q   <= 1'b0;
      barrier_open_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      pend_q         <= pend_d;
      car_prev       <= bus.car_present;
      // Outputs are decoded from the next state so they are clean flops that
      // track the state register exactly; the two motor lines are mutually
      // exclusive by construction.
      motor_up_q     <= (state_d == OPENING);
      motor_down_q   <= (state_d == CLOSING);
      barrier_open_q <= (state_d == OPEN);
    end
  end

  assign bus.motor_up     = motor_up_q;
  assign bus.motor_down   = motor_down_q;
  assign bus.barrier_open = barrier_open_q;
  assign bus.pend_cnt     = pend_q;

`ifdef GATE_TAILGATE_ALARM_EN
  logic alarm_q;
  logic alarm_set;

  // A car arriving at a closed barrier, or a passage with no authorisation
  // left, is a tailgater.
  assign alarm_set = ((state_q == CLOSED) && bus.car_present && !car_prev) ||
                     (pass_evt && pend_zero);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alarm_q <= 1'b0;
    end else if (bus.alarm_clr) begin
      alarm_q <= 1'b0;
    end else if (alarm_set) begin
      alarm_q <= 1'b1;
    end
  end

  assign bus.tailgate_alarm = alarm_q;
`else
  logic unused_alarm_clr;
  assign unused_alarm_clr   = bus.alarm_clr;
  assign bus.tailgate_alarm = 1'b0;
`endif

endmodule

// File: tb/tb_gate_barrier_ctrl.sv
// Bench for gate_barrier_ctrl: directed door scenarios, a phase/elapsed-time
// model of the barrier compared every cycle, plus hand-computed literal checks.
module tb_gate_barrier_ctrl;

  localparam int MOVE = 8;
  localparam int HOLD = 16;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

`ifdef GATE_TAILGATE_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  // Model phases of the barrier
  localparam int P_DOWN  = 0;
  localparam int P_RISE  = 1;
  localparam int P_UP    = 2;
  localparam int P_LOWER = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  gate_barrier_ctrl_if #(.PEND_W(PW)) bus ();

  gate_barrier_ctrl #(
    .MOVE_CYCLES(MOVE), .HOLD_CYCLES(HOLD), .TIMER_W(5), .PEND_W(PW)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks which phase the barrier is in, how long it has travelled, how long
  // it has been idle while up, and the queue depth of authorisations.
  int m_ph, m_elapsed, m_idle, m_pend;
  bit m_prev, m_alarm;
  bit m_pass, m_consume, m_car, m_oc;
  int m_np;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = P_DOWN; m_elapsed = 0; m_idle = 0; m_pend = 0;
      m_prev = 1'b0; m_alarm = 1'b0;
    end else begin
      m_car = bus.car_present;
      m_oc  = bus.open_cmd;
      m_pass    = (m_ph == P_UP) && m_prev && !m_car;
      m_consume = (m_ph == P_UP) && (m_pass || (m_idle == HOLD - 1 && !m_car));
      m_np = m_pend;
      if (m_oc && !m_consume)      m_np = (m_pend < PMAX) ? m_pend + 1 : PMAX;
      else if (m_consume && !m_oc) m_np = (m_pend > 0) ? m_pend - 1 : 0;
      if (ALARM_ON) begin
        if (bus.alarm_clr) m_alarm = 1'b0;
        else if ((m_ph == P_DOWN && m_car && !m_prev) || (m_pass && m_pend == 0)) m_alarm = 1'b1;
      end
      case (m_ph)
        P_DOWN:  if (m_pend > 0) begin m_ph = P_RISE; m_elapsed = 0; end
        P_RISE:  if (m_elapsed == MOVE - 1) begin m_ph = P_UP; m_idle = 0; end
                 else m_elapsed++;
        P_UP:    if (m_pend == 0 && !m_car) begin m_ph = P_LOWER; m_elapsed = 0; end
                 else if (m_car || m_consume) m_idle = 0;
                 else m_idle++;
        default: if (m_car || m_pend > 0) begin m_ph = P_RISE; m_elapsed = 0; end
                 else if (m_elapsed == MOVE - 1) m_ph = P_DOWN;
                 else m_elapsed++;
      endcase
      m_prev = m_car;
      m_pend = m_np;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset_n) begin
      check("motor_up",       32'(bus.motor_up),       32'(m_ph == P_RISE));
      check("motor_down",     32'(bus.motor_down),     32'(m_ph == P_LOWER));
      check("barrier_open",   32'(bus.barrier_open),   32'(m_ph == P_UP));
      check("pend_cnt",       32'(bus.pend_cnt),       32'(m_pend));
      check("tailgate_alarm", 32'(bus.tailgate_alarm), 32'(m_alarm));
      check("motor_excl",     32'(bus.motor_up & bus.motor_down), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic grant_one();  // leaves the bench at c1 (pend=1 registered)
    bus.open_cmd = 1'b1; tick(1); bus.open_cmd = 1'b0;
  endtask

  initial begin
    bus.open_cmd = 1'b0; bus.car_present = 1'b0; bus.alarm_clr = 1'b0;
    #3;
    check("rst_motor_up",   32'(bus.motor_up), 32'd0);
    check("rst_motor_down", 32'(bus.motor_down), 32'd0);
    check("rst_open",       32'(bus.barrier_open), 32'd0);
    check("rst_pend",       32'(bus.pend_cnt), 32'd0);
    check("rst_alarm",      32'(bus.tailgate_alarm), 32'd0);
    tick(2); reset_n = 1'b1; tick(2);

    // 1: single car passes
    grant_one();
    check("t1_pend_c1", 32'(bus.pend_cnt), 32'd1);
    check("t1_up_c1",   32'(bus.motor_up), 32'd0);
    tick(1); check("t1_up_c2", 32'(bus.motor_up), 32'd1);
    tick(7); check("t1_up_c9", 32'(bus.motor_up), 32'd1);
    check("t1_open_c9", 32'(bus.barrier_open), 32'd0);
    tick(1); check("t1_open_c10", 32'(bus.barrier_open), 32'd1);
    check("t1_up_c10", 32'(bus.motor_up), 32'd0);
    bus.car_present = 1'b1; tick(3); bus.car_present = 1'b0;
    check("t1_pend_c13", 32'(bus.pend_cnt), 32'd1);
    tick(1); check("t1_pend_c14", 32'(bus.pend_cnt), 32'd0);
    check("t1_open_c14", 32'(bus.barrier_open), 32'd1);
    tick(1); check("t1_down_c15", 32'(bus.motor_down), 32'd1);
    tick(7); check("t1_down_c22", 32'(bus.motor_down), 32'd1);
    tick(1); check("t1_down_c23", 32'(bus.motor_down), 32'd0);
    check("t1_open_c23", 32'(bus.barrier_open), 32'd0);
    tick(2);

    // 2: two back-to-back authorisations
    bus.open_cmd = 1'b1; tick(2); bus.open_cmd = 1'b0;
    check("t2_pend2", 32'(bus.pend_cnt), 32'd2);
    tick(8); check("t2_open", 32'(bus.barrier_open), 32'd1);
    bus.car_present = 1'b1; tick(2); bus.car_present = 1'b0; tick(1);
    check("t2_pend1", 32'(bus.pend_cnt), 32'd1);
    tick(3); check("t2_still_open", 32'(bus.barrier_open), 32'd1);
    bus.car_present = 1'b1; tick(2); bus.car_present = 1'b0; tick(1);
    check("t2_pend0", 32'(bus.pend_cnt), 32'd0);
    tick(1); check("t2_down", 32'(bus.motor_down), 32'd1);
    tick(8); check("t2_closed", 32'(bus.motor_down | bus.barrier_open), 32'd0);
    tick(2);

    // 3: car never arrives -> authorisation abandoned after the hold time
    grant_one(); tick(9);
    check("t3_open_c10", 32'(bus.barrier_open), 32'd1);
    tick(15); check("t3_pend_c25", 32'(bus.pend_cnt), 32'd1);
    tick(1);  check("t3_pend_c26", 32'(bus.pend_cnt), 32'd0);
    tick(1);  check("t3_down_c27", 32'(bus.motor_down), 32'd1);
    check("t3_open_c27", 32'(bus.barrier_open), 32'd0);
    tick(8);  check("t3_closed", 32'(bus.motor_down), 32'd0);
    tick(2);

    // 4: safety reversal on the 3rd closing cycle
    grant_one(); tick(9); tick(17);
    check("t4_down_c27", 32'(bus.motor_down), 32'd1);
    tick(2);
    bus.car_present = 1'b1; tick(1); bus.car_present = 1'b0;
    check("t4_down_rev", 32'(bus.motor_down), 32'd0);
    check("t4_up_rev",   32'(bus.motor_up), 32'd1);
    check("t4_pend",     32'(bus.pend_cnt), 32'd0);
    tick(7); check("t4_up_8th", 32'(bus.motor_up), 32'd1);
    tick(1); check("t4_open", 32'(bus.barrier_open), 32'd1);
    tick(1); check("t4_down_again", 32'(bus.motor_down), 32'd1);
    tick(10);

    // 5: saturation, and grant coinciding with a pass
    grant_one(); tick(9);
    bus.car_present = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.open_cmd = 1'b1; tick(1); bus.open_cmd = 1'b0; tick(1);
    end
    check("t5_sat", 32'(bus.pend_cnt), 32'd3);
    bus.car_present = 1'b0; bus.open_cmd = 1'b1; tick(1); bus.open_cmd = 1'b0;
    check("t5_cancel", 32'(bus.pend_cnt), 32'd3);
    for (int i = 0; i < 3; i++) begin
      bus.car_present = 1'b1; tick(1); bus.car_present = 1'b0; tick(1);
    end
    check("t5_drained", 32'(bus.pend_cnt), 32'd0);
    check("t5_open", 32'(bus.barrier_open), 32'd1);
    tick(1); check("t5_down", 32'(bus.motor_down), 32'd1);
    tick(10);

    // 6: reset mid-travel, then tailgate alarm
    grant_one(); tick(4);
    check("t6_up_pre", 32'(bus.motor_up), 32'd1);
    reset_n = 1'b0; #1;
    check("t6_up_async", 32'(bus.motor_up), 32'd0);
    check("t6_pend_async", 32'(bus.pend_cnt), 32'd0);
    tick(2); reset_n = 1'b1; tick(2);
    check("t6_idle_up", 32'(bus.motor_up), 32'd0);
    bus.car_present = 1'b1; bus.alarm_clr = 1'b1; tick(1);
    bus.car_present = 1'b0; bus.alarm_clr = 1'b0;
    check("t6_clr_wins", 32'(bus.tailgate_alarm), 32'd0);
    tick(1);
    bus.car_present = 1'b1; tick(1); bus.car_present = 1'b0;
    check("t6_alarm_set", 32'(bus.tailgate_alarm), 32'(ALARM_ON));
    tick(3); check("t6_alarm_sticky", 32'(bus.tailgate_alarm), 32'(ALARM_ON));
    bus.alarm_clr = 1'b1; tick(1); bus.alarm_clr = 1'b0;
    check("t6_alarm_clr", 32'(bus.tailgate_alarm), 32'd0);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
